// File: rtl/booth_product_accumulator_if.sv
// Product-in / sum-out bus for booth_product_accumulator.
//   tx        : product-ready level from booth_multiplier
//   product   : signed product, PROD_W bits
//   sum_ready : downstream accepts sum this cycle
//   sum       : signed batch sum, ACC_W bits
//   sum_valid : sum holds an unaccepted batch result
// The master modport is the side that drives tx/product/sum_ready (producer plus downstream).
// The slave modport is the accumulator.
interface booth_product_accumulator_if #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned ACC_W  = 12
);
  logic              tx;
  logic [PROD_W-1:0] product;
  logic              sum_ready;
  logic [ACC_W-1:0]  sum;
  logic              sum_valid;

  modport master (
    output tx,
    output product,
    output sum_ready,
    input  sum,
    input  sum_valid
  );

  modport slave (
    input  tx,
    input  product,
    input  sum_ready,
    output sum,
    output sum_valid
  );
endinterface

// File: rtl/booth_product_accumulator.sv
// Saturating batch accumulator placed downstream of booth_multiplier.
// Each rising edge of tx captures one signed product and adds it, clamped, into a running sum.
// After BATCH captures the sum is published on a double-buffered valid/ready output.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   bus     : slave side of the tx/product/sum handshake (see booth_product_accumulator_if)
//   clear   : synchronous clear of all state except the tx edge detector
//   count   : products accumulated in the current batch
//   overrun : sticky, a completed batch was dropped while sum was still pending
//   sat     : sticky, at least one accumulation step clamped
module booth_product_accumulator #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned ACC_W  = 12,
  parameter int unsigned BATCH  = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  booth_product_accumulator_if.slave bus,
  input  logic                       clear,
  output logic [CNT_W-1:0]           count,
  output logic                       overrun,
  output logic                       sat
);

  localparam logic [ACC_W-1:0] AccMax    = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] AccMin    = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] BatchLast = CNT_W'(BATCH - 1);

  logic             tx_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             sum_valid_q, sum_valid_d;
  logic             overrun_q, overrun_d;
  logic             sat_q, sat_d;

  logic             capture;
  logic [ACC_W:0]   wide;
  logic             ovf;
  logic [ACC_W-1:0] nxt;

  assign capture = bus.tx & ~tx_q;

  // One guard bit is enough: ACC_W >= PROD_W, so a single add can overflow by at most one bit.
  assign wide = {acc_q[ACC_W-1], acc_q}
              + {{(ACC_W + 1 - PROD_W){bus.product[PROD_W-1]}}, bus.product};
  assign ovf  = wide[ACC_W] ^ wide[ACC_W-1];
  assign nxt  = ovf ? (wide[ACC_W] ? AccMin : AccMax) : wide[ACC_W-1:0];

  always_comb begin
    acc_d       = acc_q;
    count_d     = count_q;
    sum_d       = sum_q;
    sum_valid_d = sum_valid_q;
    overrun_d   = overrun_q;
    sat_d       = sat_q;

    if (clear) begin
      acc_d       = '0;
      count_d     = '0;
      sum_d       = '0;
      sum_valid_d = 1'b0;
      overrun_d   = 1'b0;
      sat_d       = 1'b0;
    end else begin
      if (sum_valid_q && bus.sum_ready) begin
        sum_valid_d = 1'b0;
      end
      if (capture) begin
        if (ovf) begin
          sat_d = 1'b1;
        end
        if (count_q == BatchLast) begin
          acc_d   = '0;
          count_d = '0;
          // The output slot is free if empty or being drained this same cycle.
          if (!sum_valid_q || bus.sum_ready) begin
            sum_d       = nxt;
            sum_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          acc_d   = nxt;
          count_d = count_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // tx_q resets high so a tx already asserted at release is not taken as a new product.
      tx_q        <= 1'b1;
      acc_q       <= '0;
      count_q     <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      tx_q        <= bus.tx;
      acc_q       <= acc_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      overrun_q   <= overrun_d;
      sat_q       <= sat_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.sum_valid = sum_valid_q;
  assign count         = count_q;
  assign overrun       = overrun_q;
  assign sat           = sat_q;

endmodule

// File: doc/booth_product_accumulator.md
Name: booth_product_accumulator

Overview:
- Consumer stage placed directly downstream of booth_multiplier.
- Each time the multiplier raises tx, the block captures the 8-bit signed product and adds it, with saturation, into a running sum.
- After BATCH products it presents the batch sum on a valid/ready output.
- The output is double-buffered, so accumulation of the next batch continues while the previous sum waits to be accepted.

Parameters:
PROD_W, 8, width of the signed product input (matches booth_multiplier product).
ACC_W, 12, width of the signed accumulator and sum output; must be >= PROD_W.
BATCH, 4, number of products summed per output; 1..(2^CNT_W - 1).
CNT_W, 3, width of the product counter.

Ports:
CLK  input  1  rising-edge clock, the same clock as booth_multiplier.
RST_N  input  1  asynchronous active-low reset.
tx  input  1  product-ready level from booth_multiplier; may stay high for many cycles.
product  input  PROD_W  signed (two's complement) product from booth_multiplier.
clear  input  1  synchronous clear of all state.
sum_ready  input  1  downstream accepts sum this cycle.
sum  output  ACC_W  signed batch sum; held stable while sum_valid=1.
sum_valid  output  1  sum holds an unaccepted batch result.
count  output  CNT_W  products accumulated in the current batch.
overrun  output  1  sticky: a completed batch was discarded because sum was still pending.
sat  output  1  sticky: at least one accumulation saturated.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - acc, count, sum, sum_valid, overrun and sat go to 0.
  - Internal tx_q goes to 1, so a tx already high at reset release is not captured.
- Edge detect: every cycle, tx_q <= tx; capture = tx & ~tx_q. A tx held high is captured exactly once. A tx low for at least one sampled cycle re-arms capture.
- On a capture at a rising CLK edge:
  - nxt = sat_clamp(acc + sign_extend(product)) to the range [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - If clamping occurred, sat <= 1.
  - If count+1 < BATCH: acc <= nxt, count <= count+1.
  - If count+1 == BATCH: batch complete; acc <= 0, count <= 0, and publish nxt (see below).
- Publish, when a batch completes:
  - If sum_valid=0, or sum_valid=1 with sum_ready=1 in the same cycle: sum <= nxt, sum_valid <= 1. No overrun.
  - If sum_valid=1 and sum_ready=0: nxt is discarded, sum is unchanged, overrun <= 1.
- Handshake: sum_valid=1 and sum_ready=1 with no completion in that cycle gives sum_valid <= 0 next cycle. sum keeps its last value; it is only meaningful while valid.
- Latency: sum_valid rises at the CLK edge that samples the BATCH-th tx rise (1 cycle after tx first seen high).
- clear=1 (highest priority after reset):
  - acc, count, sum, sum_valid, overrun and sat <= 0.
  - tx_q still updates, so a capture coinciding with clear is dropped.
- Saturation is per-step: a clamped acc continues from the clamped value.
- sum_ready while sum_valid=0 is ignored.
- Asserting RST_N low mid-batch discards the partial sum. After release, the next tx rise starts a fresh batch with count=1.

Test Plan:
1. Default params; tx pulses with products 0x01, 0xFE, 0x31, 0xF8 (1, -2, 49, -8); sum_ready=1 -> sum_valid high for 1 cycle after the 4th capture, sum=0x028 (40), count returns to 0, sat=0, overrun=0.
2. tx held high 5 cycles with product 0x31, then low, then 3 more single pulses of 0x01 -> exactly 4 captures, sum=0x034 (52).
3. sum_ready=0; run two full batches (4×0x01 then 4×0x02) -> sum stays 0x004 with sum_valid=1, overrun=1. Then sum_ready=1 -> sum_valid=0 after one cycle.
4. sum_ready held 0 through batch 1 (sum=4). Assert sum_ready in the exact cycle batch 2 (4×0x02) completes -> sum becomes 0x008, sum_valid stays 1, overrun=0.
5. ACC_W=8; four captures of 0x40 (64) -> partial values 64, 127 (clamped), 127, 127; sum=0x7F, sat=1. Repeat with 0xC0 (-64) -> sum=0x80 (-128).
6. Two captures (count=2), then pulse RST_N low asynchronously mid-cycle with tx high -> all outputs 0 immediately. tx still high at release -> no capture. Next tx rise -> count=1. Repeat the scenario using clear instead -> same result.
